// File: rtl/cs_pkg.sv
// Shared definitions for the CS driver slice.
//   WINDOW : CS sliding-window length (results before the WINDOW-th sample are suppressed)
//   X_W    : width of a sample driven into CS
//   Y_W    : width of a CS result
//   cs_state_t : driver FSM states
package cs_pkg;

  localparam int unsigned WINDOW = 9;
  localparam int unsigned X_W    = 8;
  localparam int unsigned Y_W    = 10;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    RUN,
    DRAIN,
    FLUSH
  } cs_state_t;

endpackage

// File: rtl/cs_sync_fifo.sv
// Synchronous FIFO with show-ahead read port.
//   clk, reset   : rising-edge clock, synchronous active-high reset (drops contents)
//   push, wdata  : write request/data; ignored while full, even if a pop happens the same cycle
//   pop          : advance head; ignored while empty
//   rdata        : current head entry (valid when !empty)
//   full, empty  : occupancy flags
module cs_sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty   = (wptr == rptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/cs_driver.sv
// Upstream driver and result collector for the CS sliding-window block.
//   clk, reset              : rising-edge clock, synchronous active-high reset
//   s_valid/s_ready/s_data/s_last : host sample stream (s_ready = FIFO not full)
//   cs_reset, cs_x, cs_y    : connection to CS (cs_x registered, cs_y from CS)
//   m_valid/m_data/m_last   : fully-windowed results, one-cycle pulses, no backpressure
//   err                     : sticky underrun flag, cleared only by reset
module cs_driver #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned WINDOW     = cs_pkg::WINDOW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [cs_pkg::X_W-1:0] s_data,
  input  logic                   s_last,
  output logic                   cs_reset,
  output logic [cs_pkg::X_W-1:0] cs_x,
  input  logic [cs_pkg::Y_W-1:0] cs_y,
  output logic                   m_valid,
  output logic [cs_pkg::Y_W-1:0] m_data,
  output logic                   m_last,
  output logic                   err
);

  import cs_pkg::*;

  localparam int unsigned CNT_W = $clog2(WINDOW + 1);
  localparam int unsigned FB_W  = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] WIN_FULL = CNT_W'(WINDOW);
  localparam logic [CNT_W-1:0] WIN_QUAL = CNT_W'(WINDOW - 1);

  cs_state_t        state;
  cs_state_t        state_nxt;
  logic             fifo_full;
  logic             fifo_empty;
  logic [X_W:0]     fifo_rdata;
  logic             push;
  logic             pop;
  logic             load_x;
  logic             err_set;
  logic             head_last;
  logic [X_W-1:0]   head_data;
  logic [CNT_W-1:0] sample_cnt;
  logic [FB_W-1:0]  frames_buffered;
  logic             drain_second;

  // Valid/last tags travel alongside cs_x (stage 0) and cs_y (stage 1).
  logic             v0;
  logic             l0;
  logic             v1;
  logic             l1;

  assign s_ready   = !fifo_full;
  assign push      = s_valid && !fifo_full;
  assign head_last = fifo_rdata[X_W];
  assign head_data = fifo_rdata[X_W-1:0];
  assign cs_reset  = reset || (state == CLR);

  cs_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (X_W + 1)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata ({s_last, s_data}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load_x    = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (frames_buffered != '0 || fifo_full) state_nxt = CLR;
      end
      CLR: begin
        state_nxt = RUN;
      end
      RUN: begin
        if (fifo_empty) begin
          err_set   = 1'b1;
          state_nxt = FLUSH;
        end else begin
          pop    = 1'b1;
          load_x = 1'b1;
          if (head_last) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_second) state_nxt = IDLE;
      end
      FLUSH: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head_last) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      sample_cnt      <= '0;
      frames_buffered <= '0;
      drain_second    <= 1'b0;
      cs_x            <= '0;
      v0              <= 1'b0;
      l0              <= 1'b0;
      v1              <= 1'b0;
      l1              <= 1'b0;
      m_valid         <= 1'b0;
      m_data          <= '0;
      m_last          <= 1'b0;
      err             <= 1'b0;
    end else begin
      state        <= state_nxt;
      drain_second <= (state == DRAIN) && !drain_second;

      if (state == CLR)                        sample_cnt <= '0;
      else if (load_x && sample_cnt != WIN_FULL) sample_cnt <= sample_cnt + 1'b1;

      case ({push && s_last, pop && head_last})
        2'b10:   frames_buffered <= frames_buffered + 1'b1;
        2'b01:   frames_buffered <= frames_buffered - 1'b1;
        default: frames_buffered <= frames_buffered;
      endcase

      cs_x <= load_x ? head_data : '0;

      // sample_cnt counts samples already sent, so the popped one is the
      // WINDOW-th or later when the count has reached WINDOW-1.
      v0      <= load_x && (sample_cnt >= WIN_QUAL);
      l0      <= load_x && head_last;
      v1      <= v0;
      l1      <= l0;
      m_valid <= v1;
      m_last  <= v1 && l1;
      m_data  <= cs_y;

      if (err_set) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cs_driver.sv
module tb_cs_driver;
  import cs_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = '0;
  logic       s_last = 1'b0;
  logic       cs_reset;
  logic [7:0] cs_x;
  logic [9:0] cs_y;
  logic       m_valid;
  logic [9:0] m_data;
  logic       m_last;
  logic       err;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  cs_driver #(
    .FIFO_DEPTH (16),
    .WINDOW     (9)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .cs_reset (cs_reset),
    .cs_x     (cs_x),
    .cs_y     (cs_y),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_last   (m_last),
    .err      (err)
  );

  // Behavioural CS: 9-sample window; Y = (sum + 9*Xappr) / 8, where Xappr is
  // the largest window sample not above the integer average.
  logic [7:0] win [9];
  int         sum_w;
  int         avg_w;
  int         xa_w;
  int         y_w;

  always_ff @(posedge clk) begin
    if (cs_reset) begin
      for (int i = 0; i < 9; i++) win[i] <= '0;
    end else begin
      win[0] <= cs_x;
      for (int i = 1; i < 9; i++) win[i] <= win[i-1];
    end
  end

  always_comb begin
    sum_w = 0;
    xa_w  = 0;
    for (int i = 0; i < 9; i++) sum_w = sum_w + int'(win[i]);
    avg_w = sum_w / 9;
    for (int i = 0; i < 9; i++)
      if (int'(win[i]) <= avg_w && int'(win[i]) > xa_w) xa_w = int'(win[i]);
    y_w  = (sum_w + 9 * xa_w) / 8;
    cs_y = y_w[9:0];
  end

  // Result monitor
  typedef struct {
    logic [9:0] data;
    logic       last;
    int         cyc;
    int         rst;
  } res_t;

  res_t q[$];
  int   cyc = 0;
  int   rst_cycles = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!reset && cs_reset) rst_cycles = rst_cycles + 1;
    if (m_valid) q.push_back('{data: m_data, last: m_last, cyc: cyc, rst: rst_cycles});
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic push_frame(input int len, input int first, input int step, input bit with_last);
    for (int i = 0; i < len; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(first + i * step);
      s_last  = with_last && (i == len - 1);
      @(negedge clk);
      for (int t = 0; t < 200 && !s_ready; t++) @(negedge clk);
      if (!s_ready) begin
        total++;
        $display("FAIL push_timeout: s_ready got 0 expected 1");
      end
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  function automatic int count_last();
    int n = 0;
    foreach (q[i]) if (q[i].last) n++;
    return n;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_s_ready"},  int'(s_ready),  1);
    chk({tag, "_cs_reset"}, int'(cs_reset), 1);
    chk({tag, "_cs_x"},     int'(cs_x),     0);
    chk({tag, "_m_valid"},  int'(m_valid),  0);
    chk({tag, "_m_data"},   int'(m_data),   0);
    chk({tag, "_m_last"},   int'(m_last),   0);
    chk({tag, "_err"},      int'(err),      0);
  endtask

  typedef struct {
    int len;
    int first;
    int step;
    int exp_cnt;
    int exp_first;
    int exp_last;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int  qs;
    int  first_d;
    int  last_d;
    int  last_f;
    int  span;
    int  r0;
    bit  seen;

    vecs[0] = '{len: 9,  first: 10,  step: 0, exp_cnt: 1, exp_first: 22,  exp_last: 22};
    vecs[1] = '{len: 12, first: 1,   step: 1, exp_cnt: 4, exp_first: 11,  exp_last: 18};
    vecs[2] = '{len: 5,  first: 10,  step: 0, exp_cnt: 0, exp_first: 0,   exp_last: 0};
    vecs[3] = '{len: 9,  first: 20,  step: 0, exp_cnt: 1, exp_first: 45,  exp_last: 45};
    vecs[4] = '{len: 10, first: 100, step: 0, exp_cnt: 2, exp_first: 225, exp_last: 225};
    vecs[5] = '{len: 16, first: 255, step: 0, exp_cnt: 8, exp_first: 573, exp_last: 573};
    vecs[6] = '{len: 8,  first: 50,  step: 0, exp_cnt: 0, exp_first: 0,   exp_last: 0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Table-driven frames
    for (int v = 0; v < 7; v++) begin
      q.delete();
      push_frame(vecs[v].len, vecs[v].first, vecs[v].step, 1'b1);
      repeat (40) @(posedge clk);
      #1;
      qs      = q.size();
      first_d = (qs > 0) ? int'(q[0].data) : -1;
      last_d  = (qs > 0) ? int'(q[qs-1].data) : -1;
      last_f  = (qs > 0) ? int'(q[qs-1].last) : -1;
      span    = (qs > 0) ? q[qs-1].cyc - q[0].cyc : -1;
      chk($sformatf("v%0d_count", v), qs, vecs[v].exp_cnt);
      if (vecs[v].exp_cnt > 0) begin
        chk($sformatf("v%0d_first", v), first_d, vecs[v].exp_first);
        chk($sformatf("v%0d_lastdata", v), last_d, vecs[v].exp_last);
        chk($sformatf("v%0d_lastflag", v), last_f, 1);
        chk($sformatf("v%0d_span", v), span, vecs[v].exp_cnt - 1);
      end
      chk($sformatf("v%0d_nlast", v), count_last(), (vecs[v].exp_cnt > 0) ? 1 : 0);
      chk($sformatf("v%0d_err", v), int'(err), 0);
      chk($sformatf("v%0d_idle", v), int'(dut.state), int'(IDLE));
    end

    // 1..12 frame: check the full result sequence
    q.delete();
    push_frame(12, 1, 1, 1'b1);
    repeat (40) @(posedge clk);
    #1;
    if (q.size() == 4) begin
      chk("seq_r0", int'(q[0].data), 11);
      chk("seq_r1", int'(q[1].data), 13);
      chk("seq_r2", int'(q[2].data), 15);
      chk("seq_r3", int'(q[3].data), 18);
      chk("seq_last_early", int'(q[2].last), 0);
    end else begin
      chk("seq_size", q.size(), 4);
    end

    // Reset in mid-RUN while results are in flight
    q.delete();
    push_frame(12, 1, 1, 1'b1);
    for (int i = 0; i < 100 && dut.state != RUN; i++) begin
      @(posedge clk);
      #1;
    end
    seen = (dut.state == RUN);
    chk("reach_run", int'(seen), 1);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("midrun");
    reset = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("midrun_no_results", q.size(), 0);
    chk("midrun_idle", int'(dut.state), int'(IDLE));
    push_frame(9, 10, 0, 1'b1);
    repeat (40) @(posedge clk);
    #1;
    chk("after_reset_count", q.size(), 1);
    chk("after_reset_data", (q.size() > 0) ? int'(q[0].data) : -1, 22);

    // Back-to-back frames
    q.delete();
    r0 = rst_cycles;
    push_frame(9, 10, 0, 1'b1);
    push_frame(9, 20, 0, 1'b1);
    repeat (60) @(posedge clk);
    #1;
    chk("b2b_count", q.size(), 2);
    if (q.size() == 2) begin
      chk("b2b_d0", int'(q[0].data), 22);
      chk("b2b_d1", int'(q[1].data), 45);
      chk("b2b_l0", int'(q[0].last), 1);
      chk("b2b_l1", int'(q[1].last), 1);
      chk("b2b_clr_between", q[1].rst - q[0].rst, 1);
    end
    chk("b2b_clr_total", rst_cycles - r0, 2);

    // Underrun: 16 samples without last fill the FIFO
    q.delete();
    push_frame(16, 1, 1, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    qs = q.size();
    chk("under_err", int'(err), 1);
    chk("under_count", qs, 8);
    chk("under_first", (qs > 0) ? int'(q[0].data) : -1, 11);
    chk("under_lastdata", (qs > 0) ? int'(q[qs-1].data) : -1, 27);
    chk("under_nlast", count_last(), 0);
    q.delete();
    push_frame(3, 5, 0, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    chk("flush_no_results", q.size(), 0);
    chk("flush_err_sticky", int'(err), 1);
    chk("flush_idle", int'(dut.state), int'(IDLE));
    chk("flush_ready", int'(s_ready), 1);
    chk("flush_frames", int'(dut.frames_buffered), 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("err_cleared", int'(err), 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
